// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter merging NUM_REQ beat streams into a single FIFO write port.
// Define FIFO_WR_ARB_CNT_EN to build the beat_total transfer counter; otherwise it reads 0.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic [31:0]                   beat_total
);

  localparam int unsigned GW = $clog2(NUM_REQ);
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST_LEN - 1);
  localparam logic [GW-1:0] LAST_RST = GW'(NUM_REQ - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [GW-1:0]  grant_q, grant_d;
  logic [GW-1:0]  last_q, last_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [GW-1:0]  rr_win;
  int unsigned    rr_dist;
  int unsigned    rr_best;
  logic           end_burst;

  // Winner is the valid requester at the smallest distance past last_q.
  always_comb begin
    rr_win  = '0;
    rr_best = NUM_REQ;
    rr_dist = 0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      rr_dist = (32'(i) + NUM_REQ - 32'd1 - 32'(last_q)) % NUM_REQ;
      if (req_valid[i] && (rr_dist < rr_best)) begin
        rr_best = rr_dist;
        rr_win  = GW'(i);
      end
    end
  end

  always_comb begin
    busy         = (state_q == GRANT);
    grant_id     = grant_q;
    req_ready    = '0;
    fifo_wr_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_q == GW'(i)) begin
        req_ready[i] = busy & ~fifo_full;
        fifo_wr_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    fifo_wr_en = busy & req_valid[grant_q] & ~fifo_full;
    end_burst  = req_last[grant_q] | (cnt_q == CNT_LAST);
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d = GRANT;
          grant_d = rr_win;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        // A beat moves only when the FIFO has room and the granted source is valid.
        if (fifo_wr_en) begin
          cnt_d = cnt_q + CW'(1);
          if (end_burst) begin
            state_d = IDLE;
            last_d  = grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FIFO_WR_ARB_CNT_EN
  logic [31:0] total_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q <= '0;
    end else if (fifo_wr_en) begin
      total_q <= total_q + 32'd1;
    end
  end

  assign beat_total = total_q;
`else
  assign beat_total = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic against a cycle model.
module tb_fifo_wr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned BL = 4;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_wr_data;
  logic [1:0]      grant_id;
  logic            busy;
  logic [31:0]     beat_total;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .grant_id(grant_id),
    .busy(busy), .beat_total(beat_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: who holds the grant, how many beats it has moved, who went last.
  bit          m_busy;
  logic [1:0]  m_g;
  logic [1:0]  m_last;
  int          m_beats;
  logic [31:0] m_total;

  // Requester streams.
  int   sent[N];
  int   tot[N];
  int   plen[N];
  bit   gate[N];
  bit   rand_gaps;
  bit   prev_busy;
  logic [7:0] dlog[$];
  logic [1:0] olog[$];

  function automatic logic [7:0] dat(int i);
    return 8'(i * 64 + sent[i] % 64);
  endfunction

  function automatic void model_reset();
    m_busy  = 1'b0;
    m_g     = 2'd0;
    m_last  = 2'(N - 1);
    m_beats = 0;
    m_total = 32'd0;
  endfunction

  function automatic bit all_done();
    bit d;
    d = !m_busy;
    for (int i = 0; i < N; i++) if (sent[i] < tot[i]) d = 1'b0;
    return d;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (sent[i] < tot[i]) && gate[i] && (!rand_gaps || ($urandom_range(0, 3) != 0));
      req_data[i*DW +: DW] = dat(i);
      req_last[i] = ((sent[i] % plen[i]) == plen[i] - 1) || (sent[i] == tot[i] - 1);
    end
  endtask

  function automatic logic [47:0] expv();
    logic [3:0]  rdy;
    logic        wen;
    logic [7:0]  d;
    logic [31:0] te;
    rdy = (m_busy && !fifo_full) ? 4'(1 << m_g) : 4'h0;
    wen = m_busy && req_valid[m_g] && !fifo_full;
    d   = wen ? dat(int'(m_g)) : 8'h00;
`ifdef FIFO_WR_ARB_CNT_EN
    te  = m_total;
`else
    te  = 32'd0;
`endif
    return {rdy, wen, d, m_g, m_busy, te};
  endfunction

  function automatic logic [47:0] obs();
    return {req_ready, fifo_wr_en, (fifo_wr_en ? fifo_wr_data : 8'h00), grant_id, busy, beat_total};
  endfunction

  function automatic void log_obs();
    if (fifo_wr_en === 1'b1) dlog.push_back(fifo_wr_data);
    if (busy === 1'b1 && !prev_busy) olog.push_back(grant_id);
    prev_busy = (busy === 1'b1);
  endfunction

  // Advance the model across one rising edge using the inputs now applied.
  function automatic void advance();
    bit wen;
    bit found;
    wen = m_busy && req_valid[m_g] && !fifo_full;
    if (!m_busy) begin
      if (|req_valid) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          if (!found && req_valid[2'(int'(m_last) + k)]) begin
            found = 1'b1;
            m_g   = 2'(int'(m_last) + k);
          end
        end
        m_busy  = 1'b1;
        m_beats = 0;
      end
    end else if (wen) begin
      m_beats++;
      m_total++;
      if (req_last[m_g] || m_beats == BL) begin
        m_last = m_g;
        m_busy = 1'b0;
      end
      sent[m_g]++;
    end
  endfunction

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    rand_gaps = 1'b0;
    for (int i = 0; i < N; i++) begin
      gate[i] = 1'b1; sent[i] = 0; tot[i] = 0; plen[i] = 1;
    end
    model_reset();
    dlog.delete();
    olog.delete();
    prev_busy = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      req_valid = 4'($urandom);
      req_last  = 4'($urandom);
      req_data  = 32'($urandom);
      #1;
      n_checks++;
      if (obs() !== expv()) $display("FAIL reset cyc %0d: got %h exp %h", c, obs(), expv());
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_single_burst();
    logic [7:0] e;
    do_reset();
    tot[0] = 6; plen[0] = 6;
    for (int c = 0; c < 40; c++) begin
      if (all_done()) break;
      drive(); #1;
      n_checks++;
      if (obs() !== expv()) $display("FAIL single_burst cyc %0d: got %h exp %h", c, obs(), expv());
      else n_pass++;
      log_obs(); advance(); @(negedge clk);
    end
    n_checks++;
    if (!all_done() || dlog.size() != 6) $display("FAIL single_burst_len: got %0d beats exp 6", dlog.size());
    else n_pass++;
    for (int k = 0; k < 6 && k < dlog.size(); k++) begin
      e = 8'(k);
      n_checks++;
      if (dlog[k] !== e) $display("FAIL single_burst_data[%0d]: got %h exp %h", k, dlog[k], e);
      else n_pass++;
    end
    n_checks++;
    if (olog.size() != 2 || olog[0] !== 2'd0 || olog[1] !== 2'd0)
      $display("FAIL single_burst_grants: got %0d grants exp 2 to requester 0", olog.size());
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [1:0] e;
    do_reset();
    for (int i = 0; i < N; i++) begin tot[i] = 2; plen[i] = 1; end
    for (int c = 0; c < 60; c++) begin
      if (all_done()) break;
      drive(); #1;
      n_checks++;
      if (obs() !== expv()) $display("FAIL round_robin cyc %0d: got %h exp %h", c, obs(), expv());
      else n_pass++;
      log_obs(); advance(); @(negedge clk);
    end
    n_checks++;
    if (!all_done() || olog.size() != 8) $display("FAIL round_robin_len: got %0d grants exp 8", olog.size());
    else n_pass++;
    for (int k = 0; k < 8 && k < olog.size(); k++) begin
      e = 2'(k % 4);
      n_checks++;
      if (olog[k] !== e) $display("FAIL round_robin_order[%0d]: got %0d exp %0d", k, olog[k], e);
      else n_pass++;
    end
  endtask

  task automatic test_full_stall();
    int stall = 0;
    int stall_wr = 0;
    do_reset();
    tot[2] = 4; plen[2] = 4;
    for (int c = 0; c < 40; c++) begin
      if (all_done()) break;
      fifo_full = (sent[2] == 2) && (stall < 5);
      if (fifo_full) stall++;
      drive(); #1;
      n_checks++;
      if (obs() !== expv()) $display("FAIL full_stall cyc %0d: got %h exp %h", c, obs(), expv());
      else n_pass++;
      if (fifo_full && (fifo_wr_en !== 1'b0 || req_ready !== 4'h0)) stall_wr++;
      log_obs(); advance(); @(negedge clk);
    end
    fifo_full = 1'b0;
    n_checks++;
    if (stall_wr != 0) $display("FAIL full_stall_writes: got %0d active cycles exp 0", stall_wr);
    else n_pass++;
    n_checks++;
    if (!all_done() || dlog.size() != 4 || dlog[0] !== 8'h80 || dlog[3] !== 8'h83 || olog.size() != 1)
      $display("FAIL full_stall_burst: got %0d beats %0d grants exp 4 beats 1 grant", dlog.size(), olog.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    tot[1] = 4; plen[1] = 4;
    for (int c = 0; c < 20; c++) begin
      if (sent[1] == 2) break;
      drive(); #1;
      n_checks++;
      if (obs() !== expv()) $display("FAIL reset_mid pre cyc %0d: got %h exp %h", c, obs(), expv());
      else n_pass++;
      log_obs(); advance(); @(negedge clk);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (obs() !== expv() || busy !== 1'b0 || fifo_wr_en !== 1'b0)
      $display("FAIL reset_mid_async: got %h exp %h", obs(), expv());
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) sent[i] = 0;
    tot[0] = 3; plen[0] = 3; tot[1] = 3; plen[1] = 3;
    dlog.delete(); olog.delete(); prev_busy = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (all_done()) break;
      drive(); #1;
      n_checks++;
      if (obs() !== expv()) $display("FAIL reset_mid post cyc %0d: got %h exp %h", c, obs(), expv());
      else n_pass++;
      log_obs(); advance(); @(negedge clk);
    end
    n_checks++;
    if (!all_done() || olog.size() != 2 || olog[0] !== 2'd0 || olog[1] !== 2'd1 || dlog[0] !== 8'h00)
      $display("FAIL reset_mid_order: got %0d grants first %0d exp grants 0 then 1", olog.size(), olog[0]);
    else n_pass++;
  endtask

  task automatic test_valid_gap();
    int gap = 0;
    do_reset();
    tot[3] = 4; plen[3] = 4; tot[0] = 2; plen[0] = 2;
    for (int c = 0; c < 40; c++) begin
      if (all_done()) break;
      gate[0] = (sent[3] >= 1);
      gate[3] = !((sent[3] >= 1) && (gap < 3));
      if (!gate[3]) gap++;
      drive(); #1;
      n_checks++;
      if (obs() !== expv()) $display("FAIL valid_gap cyc %0d: got %h exp %h", c, obs(), expv());
      else n_pass++;
      log_obs(); advance(); @(negedge clk);
    end
    n_checks++;
    if (!all_done() || olog.size() != 2 || olog[0] !== 2'd3 || olog[1] !== 2'd0 || dlog.size() != 6 || dlog[4] !== 8'h00)
      $display("FAIL valid_gap_order: got %0d grants %0d beats exp grants 3 then 0, 6 beats", olog.size(), dlog.size());
    else n_pass++;
  endtask

  task automatic test_beat_total();
    logic [31:0] e;
    do_reset();
    tot[0] = 4; tot[1] = 3; tot[2] = 3;
    for (int i = 0; i < N; i++) plen[i] = 2;
    for (int c = 0; c < 60; c++) begin
      if (all_done()) break;
      drive(); #1;
      n_checks++;
      if (obs() !== expv()) $display("FAIL beat_total cyc %0d: got %h exp %h", c, obs(), expv());
      else n_pass++;
      log_obs(); advance(); @(negedge clk);
    end
`ifdef FIFO_WR_ARB_CNT_EN
    e = 32'd10;
`else
    e = 32'd0;
`endif
    #1;
    n_checks++;
    if (!all_done() || beat_total !== e) $display("FAIL beat_total_final: got %0d exp %0d", beat_total, e);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    rand_gaps = 1'b1;
    for (int i = 0; i < N; i++) begin
      tot[i]  = int'($urandom_range(5, 20));
      plen[i] = int'($urandom_range(1, 6));
    end
    for (int c = 0; c < 3000; c++) begin
      if (all_done()) break;
      fifo_full = ($urandom_range(0, 3) == 0);
      drive(); #1;
      n_checks++;
      if (obs() !== expv()) $display("FAIL random cyc %0d: got %h exp %h", c, obs(), expv());
      else n_pass++;
      log_obs(); advance(); @(negedge clk);
    end
    fifo_full = 1'b0;
    n_checks++;
    if (!all_done()) $display("FAIL random_timeout: got unfinished traffic exp all streams drained");
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_full_stall();
    test_reset_mid_burst();
    test_valid_gap();
    test_beat_total();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
